mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the CPU's single-ported unified memory between the instruction-fetch stage and the load/store stage of the RV32I core. It accepts one request at a time and sequences the memory access through a fixed-latency read path. It returns read data or a write acknowledgement to the winning requester. It sits between the CPU datapath and the memory model instantiated alongside `CPU`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from the `mem_en` cycle to `mem_rdata` valid (≥1)
- `STARVE_MAX`, 4, maximum consecutive data grants while a fetch is pending
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted (1-cycle pulse)
- `if_valid`  out  1  fetch data valid (1-cycle pulse)
- `if_rdata`  out  DATA_W  fetch data, stable from `if_valid` until next fetch response
- `d_req`  in  1  data request; held with attributes stable until `d_gnt`
- `d_we`  in  1  1 = store
- `d_be`  in  DATA_W/8  byte enables for stores
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data accepted (1-cycle pulse)
- `d_valid`  out  1  load data / store ack (1-cycle pulse)
- `d_rdata`  out  DATA_W  load data; 0 for stores
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- FSM states:
  - `IDLE`: arbitrate; on a winner, assert its `gnt` combinationally, capture requester id, address, we, be and wdata, then go to `ISSUE`.
  - `ISSUE`: drive `mem_en`=1 for one cycle, plus `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` from the captured registers. Go to `WAIT`.
  - `WAIT`: stay for MEM_LAT cycles, counted by a down-counter. On the last WAIT cycle, register `mem_rdata` into the response register of the owner (0 if store). Go to `RESP`.
  - `RESP`: pulse the owner's `valid`, then go to `IDLE`.
- Arbitration in `IDLE`:
  - Data wins over fetch by default.
  - Fetch wins when `if_req`=1 and `streak`==STARVE_MAX.
- `streak` counter:
  - Increments, saturating at STARVE_MAX, on each data grant while `if_req`=1.
  - Clears on any fetch grant.
  - Unchanged on a data grant with `if_req`=0.
- Fetches are always reads.
- One transaction outstanding. No request is granted outside `IDLE`.
- Outside `ISSUE`: `mem_en`=`mem_we`=0 and `mem_be`=0. `mem_addr` and `mem_wdata` hold their last values.
- Addresses pass through unmodified. Alignment is the datapath's responsibility.
- Reset (`rst`=0 at a clock edge), from any state:
  - State goes to `IDLE`, `streak` to 0, all outputs to 0, response registers to 0.
  - Any in-flight transaction is dropped; no `valid` pulse follows.

## Timing
- Accept at cycle T (IDLE, `gnt`=1), then:
  - T+1: `mem_en`.
  - T+2 … T+1+MEM_LAT: WAIT.
  - T+2+MEM_LAT: `valid`.
- Minimum spacing between grants: MEM_LAT+3 cycles. The next grant is possible at T+3+MEM_LAT.
- `gnt` depends only on state, `if_req`, `d_req` and `streak`. It never depends on `mem_rdata`.
- Simultaneous `if_req`/`d_req`: resolved only by the priority rule above.
- A request deasserted before `gnt` is never serviced.
- After reset is released, the first grant occurs no earlier than the first cycle with `rst`=1.

## Structure
- Shared header `mem_defs.vh`:
  - FSM state encodings (2 bits).
  - Requester ids `REQ_IF`/`REQ_D`.
  - Default widths.
- Sub-module `mem_arb_pick`: combinational priority/starvation selector.
  - Inputs: `if_req`, `d_req`, `streak`.
  - Outputs: `grant_if`, `grant_d`.
- FSM, counters and capture registers live in `mem_arbiter`.

## Test plan
- Single fetch, MEM_LAT=1: `if_req`, `if_addr`=0x0000_0010, memory word 0x0000_0093.
  - `if_gnt` at T, `mem_en`/`mem_addr`=0x10 at T+1, `if_valid` with `if_rdata`=0x0000_0093 at T+3.
- Store then load, same address 0x100:
  - Store `d_we`=1, `d_be`=4'b0011, `d_wdata`=0xDEAD_BEEF onto a word holding 0x1122_3344: `mem_be`=4'b0011, `d_valid` with `d_rdata`=0.
  - Following load: `d_rdata`=0x1122_BEEF.
- Contention, STARVE_MAX=4: `if_req` and `d_req` held high continuously.
  - Grant order D,D,D,D,IF,D,D,D,D,IF.
  - Never more than 4 consecutive data grants.
- MEM_LAT=3: single load.
  - `d_valid` exactly 5 cycles after `d_gnt`.
  - `mem_en` high for exactly 1 cycle.
- Reset mid-operation: assert `rst`=0 in the WAIT cycle of a load.
  - Next cycle all outputs 0.
  - No `d_valid` pulse ever appears for that load.
  - A fresh request after `rst`=1 completes normally.
- Withdrawn request:
  - `if_req` high for one cycle while a data transaction is in flight, then low → no `if_gnt`, no fetch access.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared types and defaults for the unified-memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Requester ids
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  // Default widths and timing
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  // Number of bits needed to hold the value n (at least 1)
  function automatic int width_for(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module : mem_arb_pick
// Brief  : Combinational data-over-fetch priority with starvation override.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_pick #(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output logic          grant_if,
  output logic          grant_d
);

  logic starved;

  // Fetch wins only when data is absent or fetch has waited out the streak
  always_comb begin
    starved  = (streak == SW'(STARVE_MAX));
    grant_if = if_req && (!d_req || starved);
    grant_d  = d_req && !grant_if;
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Single-outstanding arbiter of unified memory between the fetch
//          and load/store stages, with a fixed-latency read path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = width_for(STARVE_MAX);
  localparam int CW   = width_for(MEM_LAT);

  state_t            state;
  req_id_t           owner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     streak;
  logic              pick_if;
  logic              pick_d;
  logic              can_grant;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
    .streak   (streak),
    .grant_if (pick_if),
    .grant_d  (pick_d)
  );

  // Grants only in IDLE and never while reset is being applied
  always_comb begin
    can_grant = (state == ST_IDLE) && rst;
    if_gnt    = can_grant && pick_if;
    d_gnt     = can_grant && pick_d;
  end

  // Memory strobes decode from the state register; address/data hold the capture
  always_comb begin
    mem_en    = (state == ST_ISSUE);
    mem_we    = mem_en && we_q;
    mem_be    = mem_en ? be_q : '0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_valid  = (state == ST_RESP) && (owner == REQ_IF);
    d_valid   = (state == ST_RESP) && (owner == REQ_D);
  end

  // Arbiter FSM with request capture, latency counter and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      owner    <= REQ_IF;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      streak   <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_if) begin
            // Fetches are full-word reads
            owner   <= REQ_IF;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            be_q    <= '1;
            wdata_q <= '0;
            streak  <= '0;
            state   <= ST_ISSUE;
          end else if (pick_d) begin
            owner   <= REQ_D;
            addr_q  <= d_addr;
            we_q    <= d_we;
            be_q    <= d_be;
            wdata_q <= d_wdata;
            if (if_req && (streak != SW'(STARVE_MAX))) begin
              streak <= streak + SW'(1);
            end
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= CW'(MEM_LAT - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            if (owner == REQ_IF) begin
              if_rdata <= mem_rdata;
            end else begin
              d_rdata <= we_q ? '0 : mem_rdata;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench; two arbiters (read latency 1 and 3), each
//          with its own memory model, checked against a transaction model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic [1:0]       if_req, if_gnt, if_valid;
  logic [1:0][31:0] if_addr, if_rdata;
  logic [1:0]       d_req, d_we, d_gnt, d_valid;
  logic [1:0][3:0]  d_be;
  logic [1:0][31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]       mem_en, mem_we;
  logic [1:0][3:0]  mem_be;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [2][256];
  logic [31:0] last_if [2];
  logic [31:0] last_d  [2];

  // Initial memory contents, shared by the memory models and the reference
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h10)  return 32'h0000_0093;
    if (a == 32'h100) return 32'h1122_3344;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];

    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_gnt    (if_gnt[g]),
      .if_valid  (if_valid[g]),
      .if_rdata  (if_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_be      (d_be[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_valid   (d_valid[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_be    (mem_be[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(32'(i * 4));
      for (int i = 0; i < LAT; i++) pipe[i] = 32'hBADC_0FFE;
    end

    // Memory model: read data appears LAT cycles after the strobe cycle
    always @(posedge clk) begin
      pipe[0] <= mem_en[g] ? mem[mem_addr[g][9:2]] : 32'hBADC_0FFE;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (mem_en[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[g][b]) mem[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        end
      end
    end

    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input int k, input string tag);
    chk(tag, {23'b0, mem_be[k], mem_we[k], mem_en[k], if_gnt[k], d_gnt[k],
              if_valid[k], d_valid[k]}, 32'd0);
  endtask

  task automatic zero_checks(input int k, input string tag);
    idle_checks(k, tag);
    chk({tag, "_if_rdata"}, if_rdata[k], 32'd0);
    chk({tag, "_d_rdata"}, d_rdata[k], 32'd0);
    chk({tag, "_mem_addr"}, mem_addr[k], 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata[k], 32'd0);
  endtask

  // One isolated transaction: grant, issue, wait, respond, back to idle
  task automatic txn(input int k, input bit is_if, input bit we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit poke);
    int n;
    int lat;
    logic [31:0] exp;
    lat = (k == 0) ? 1 : 3;
    tick();
    if (is_if) begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end else begin
      d_req[k] = 1'b1; d_we[k] = we; d_be[k] = be; d_addr[k] = addr; d_wdata[k] = wdata;
    end
    #1;
    n = 0;
    while (!(is_if ? if_gnt[k] : d_gnt[k]) && n < 20) begin
      tick(); #1; n++;
    end
    chk("gnt", {30'b0, if_gnt[k], d_gnt[k]}, is_if ? 32'd2 : 32'd1);
    chk("gnt_mem_en", 32'(mem_en[k]), 32'd0);
    tick();
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    if_addr[k] = $urandom; d_addr[k] = $urandom; d_wdata[k] = $urandom;
    d_be[k] = 4'($urandom); d_we[k] = 1'($urandom);
    #1;
    chk("issue_en_gnt", {29'b0, mem_en[k], if_gnt[k], d_gnt[k]}, 32'd4);
    chk("issue_addr", mem_addr[k], addr);
    chk("issue_we", 32'(mem_we[k]), is_if ? 32'd0 : 32'(we));
    if (!is_if) chk("issue_be", 32'(mem_be[k]), 32'(be));
    if (!is_if && we) chk("issue_wdata", mem_wdata[k], wdata);
    for (int i = 0; i < lat; i++) begin
      tick();
      if (poke) if_req[k] = (i == 0);
      #1;
      idle_checks(k, "wait");
    end
    tick();
    if (poke) if_req[k] = 1'b0;
    #1;
    if (is_if || !we) exp = ref_mem[k][addr[9:2]];
    else exp = 32'd0;
    chk("resp_valid", {30'b0, if_valid[k], d_valid[k]}, is_if ? 32'd2 : 32'd1);
    chk("resp_quiet", {29'b0, mem_en[k], if_gnt[k], d_gnt[k]}, 32'd0);
    if (is_if) begin
      chk("if_rdata", if_rdata[k], exp);
      chk("d_rdata_hold", d_rdata[k], last_d[k]);
      last_if[k] = exp;
    end else begin
      chk("d_rdata", d_rdata[k], exp);
      chk("if_rdata_hold", if_rdata[k], last_if[k]);
      last_d[k] = exp;
    end
    if (!is_if && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[k][addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    tick(); #1;
    idle_checks(k, "post");
  endtask

  // Both requesters held: fetch may win only after four data grants in a row
  task automatic contention(input int k, input int ngrants);
    int n, lat, consec, run, maxrun;
    bit exp_if;
    lat = (k == 0) ? 1 : 3;
    consec = 0; run = 0; maxrun = 0;
    tick();
    if_req[k] = 1'b1; if_addr[k] = 32'h40;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_be[k] = 4'hF; d_addr[k] = 32'h80;
    #1;
    for (int g = 0; g < ngrants; g++) begin
      n = 0;
      if (g > 0) begin tick(); #1; n = 1; end
      while (!(if_gnt[k] || d_gnt[k]) && n < lat + 8) begin
        tick(); #1; n++;
      end
      if (g > 0) chk("cont_spacing", 32'(n), 32'(lat + 3));
      exp_if = (consec == 4);
      chk("cont_order", {30'b0, if_gnt[k], d_gnt[k]}, exp_if ? 32'd2 : 32'd1);
      if (exp_if) consec = 0;
      else consec = (consec < 4) ? consec + 1 : 4;
      run = d_gnt[k] ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    chk("cont_max_run", 32'(maxrun <= 4), 32'd1);
    tick();
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    #1;
    for (int i = 0; i < lat + 3; i++) begin
      tick(); #1;
      chk("cont_drain_gnt", {30'b0, if_gnt[k], d_gnt[k]}, 32'd0);
    end
    last_if[k] = ref_mem[k][8'h10];
    last_d[k]  = ref_mem[k][8'h20];
    chk("cont_if_rdata", if_rdata[k], last_if[k]);
    chk("cont_d_rdata", d_rdata[k], last_d[k]);
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b0;
    if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_be = '0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(32'(i * 4));
      last_if[k] = 32'd0; last_d[k] = 32'd0;
    end

    // Reset state, with a request present that must not be granted
    tick(); tick();
    if_req[0] = 1'b1; d_req[1] = 1'b1;
    #1;
    zero_checks(0, "rst0");
    zero_checks(1, "rst1");
    tick();
    if_req = '0; d_req = '0; rst = 1'b1;
    #1;

    // Single fetch, store then load at the same word
    txn(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'd0, 1'b0);
    txn(0, 1'b0, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    txn(0, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'd0, 1'b0);
    chk("merged_word", d_rdata[0], 32'h1122_BEEF);

    contention(0, 10);

    // Fetch request withdrawn while a load is in flight
    txn(0, 1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      idle_checks(0, "withdrawn");
    end

    // Long latency load
    txn(1, 1'b0, 1'b0, 4'hF, 32'h0000_0030, 32'd0, 1'b0);

    // Reset during the first WAIT cycle of a load
    tick();
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_be[1] = 4'hF; d_addr[1] = 32'h200;
    #1;
    chk("rst_test_gnt", 32'(d_gnt[1]), 32'd1);
    tick();
    d_req[1] = 1'b0;
    #1;
    chk("rst_test_issue", 32'(mem_en[1]), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    tick();
    d_req[1] = 1'b1;
    #1;
    zero_checks(1, "midrst1");
    zero_checks(0, "midrst0");
    tick();
    d_req[1] = 1'b0; rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin last_if[k] = 32'd0; last_d[k] = 32'd0; end
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      idle_checks(1, "after_rst");
    end
    txn(1, 1'b0, 1'b0, 4'hF, 32'h0000_0200, 32'd0, 1'b0);

    contention(1, 10);

    // Randomized isolated transactions on both arbiters
    for (int t = 0; t < 40; t++) begin
      ra = {22'b0, 8'($urandom), 2'b0};
      txn(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 4'($urandom),
          ra, $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
